// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the adder tree, the neuron accumulator and the next layer.
// master drives partial sums and consumes activations; slave is the accumulator.
interface neuron_accumulator_if #(
  parameter int unsigned N = 16
);
  logic         abort;
  logic [N-1:0] bias;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output abort, bias, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  abort, bias, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/neuron_accumulator.sv
// Accumulates NUM_CHUNKS signed-magnitude partial sums plus a bias, then emits one
// ReLU'd / saturated signed-magnitude activation over valid/ready.
module neuron_accumulator #(
  parameter int unsigned N          = 16,
  parameter int unsigned NUM_CHUNKS = 4,
  parameter int unsigned RELU_EN    = 1,
  parameter int unsigned ACC_W      = N + 6
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic signed [ACC_W-1:0] MAX_MAG =
    $signed({{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}});

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N-1:0]            out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;

  // Signed magnitude to two's complement; negative zero falls out as zero.
  function automatic logic signed [ACC_W-1:0] sm2tc(input logic [N-1:0] x);
    logic signed [ACC_W-1:0] mag;
    mag = $signed({{(ACC_W-N+1){1'b0}}, x[N-2:0]});
    return x[N-1] ? -mag : mag;
  endfunction

  // Optional ReLU, saturate the magnitude, back to signed magnitude without -0.
  function automatic logic [N-1:0] finalize(input logic signed [ACC_W-1:0] x);
    logic                    neg;
    logic signed [ACC_W-1:0] ax;
    logic [N-2:0]            mag;
    neg = x[ACC_W-1];
    ax  = neg ? -x : x;
    if (ax > MAX_MAG) begin
      mag = '1;
    end else begin
      mag = ax[N-2:0];
    end
    if ((RELU_EN != 0) && neg) begin
      return '0;
    end
    return {neg && (mag != '0), mag};
  endfunction

  assign accept   = bus.in_valid && in_ready_q;
  assign acc_base = (state_q == S_IDLE) ? sm2tc(bus.bias) : acc_q;
  assign acc_sum  = acc_base + sm2tc(bus.in_data);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (bus.abort) begin
      state_d     = S_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_d = acc_sum;
            cnt_d = CNT_W'(1);
            if (NUM_CHUNKS == 1) begin
              state_d     = S_OUT;
              out_data_d  = finalize(acc_sum);
              out_valid_d = 1'b1;
            end else begin
              state_d = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
              state_d     = S_OUT;
              out_data_d  = finalize(acc_sum);
              out_valid_d = 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_valid_q && bus.out_ready) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end

    // Handshake flags track the state being entered so they are flop outputs.
    in_ready_d = (state_d != S_OUT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule
